hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline controller for the 16-bit five-stage core; it sequences the execute stage and its neighbouring pipeline registers.
- Produces forwarding selects for the execute-stage ALU operands.
- Produces stall/flush controls for the F/D/E/M/W pipeline registers, covering load-use hazards, taken branches/jumps (PCSrcE) and data-memory wait states.
- Includes a wait-state timeout FSM and saturating performance counters.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- MEM_TIMEOUT, 15, maximum consecutive memory wait cycles before the error state (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- Rs1D, Rs2D  in  4  source registers of the instruction in decode.
- Rs1E, Rs2E  in  4  source registers of the instruction in execute.
- RdE, RdM, RdW  in  4  destination registers in E/M/W.
- resultSrcE  in  2  result source in E; 2'b01 = load.
- regWriteM, regWriteW  in  1  register write enables in M/W.
- PCSrcE  in  1  taken branch/jump resolved in E.
- memAccessM  in  1  load or store in M.
- memReadyM  in  1  data memory completes the access this cycle.
- forwardAE, forwardBE  out  2  operand select: 00 = RD1E/RD2E, 10 = aluResM, 01 = result in W.
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register / PC.
- flushD, flushE, flushW  out  1  load a bubble into the D/E/W register.
- memErr  out  1  sticky wait-state timeout flag.
- stallCount  out  CNT_W  cycles with stallF=1.
- flushCount  out  CNT_W  branch flush events.
- lwCount  out  CNT_W  load-use stall events.

Behaviour:
- Reset (rst=0 at posedge):
  - state=RUN, waitCnt=0, memErr=0, all counters=0.
  - While rst=0, every stall/flush output is 0 and forwardAE/BE=00.
- Forwarding (combinational, all states):
  - forwardAE=10 if regWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise forwardAE=01 if regWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise forwardAE=00.
  - M has priority over W. forwardBE is identical using Rs2E. R0 is never forwarded.
- lwHaz = (resultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, MEM_WAIT, ERROR.
- RUN, priority order:
  1. memAccessM && !memReadyM:
     - stallF=stallD=stallE=stallM=1, flushW=1.
     - Next state MEM_WAIT, waitCnt=1.
     - A pending PCSrcE or lwHaz is not acted on; both persist because E and D are held.
  2. Else PCSrcE: flushD=flushE=1, stalls=0; flushCount++. Overrides lwHaz.
  3. Else lwHaz: stallF=stallD=1, flushE=1; lwCount++.
  4. Else all stall/flush outputs=0.
- MEM_WAIT:
  - If memReadyM=1: the cycle is evaluated exactly as RUN rules 2-4; next state RUN, waitCnt=0.
  - Else: stallF/D/E/M=1, flushW=1, waitCnt++.
  - If waitCnt==MEM_TIMEOUT and memReadyM=0: next state ERROR, memErr=1.
- ERROR:
  - stallF/D/E/M=1, flushW=1 permanently; memErr=1.
  - Only rst exits ERROR.
- Counters:
  - stallCount increments every cycle with stallF=1.
  - All counters saturate at 2^CNT_W-1; no wrap.
  - Counters update on the same posedge that ends the cycle in which the event was asserted.
- Latency: all stall/flush/forward outputs are combinational from the current state and inputs (zero-cycle). State and counters are registered.
- Reset mid-wait or in ERROR returns to RUN on the next posedge; no stale stall outputs after that.

Test Plan:
- Forwarding: regWriteM=1, RdM=3, Rs1E=3, regWriteW=1, RdW=3, Rs2E=3 -> forwardAE=10, forwardBE=10. Then RdM=4 -> forwardBE=01. Then RdM=RdW=Rs1E=0 -> forwardAE=00.
- Load-use: resultSrcE=01, RdE=5, Rs2D=5 for one cycle -> stallF=stallD=flushE=1; next cycle (E bubble) all 0; lwCount=1.
- Branch vs load-use: PCSrcE=1 together with lwHaz -> flushD=flushE=1, stallF=0; flushCount=1, lwCount=0.
- Wait states: memAccessM=1, memReadyM=0 for 3 cycles then 1 -> stallF/D/E/M and flushW high 3 cycles, low in the ready cycle; stallCount=3; state RUN.
- Timeout: memReadyM held 0 for 20 cycles with MEM_TIMEOUT=15 -> memErr=1 after cycle 15 and stays 1 with stalls held. rst=0 for one cycle -> memErr=0, outputs 0, counters 0.
- Saturation: CNT_W=4, 20 consecutive branch flushes -> flushCount stops at 15.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Pipeline hazard interface.
// Groups the pipeline-side signals seen by the hazard unit.
//   master : pipeline side. Drives register ids and hazard sources, and receives the
//            forwarding selects, stall/flush controls and performance counters.
//   slave  : hazard unit side (the reverse directions).
// Parameter CNT_W sets the width of the counters. It must match the hazard_unit instance.
interface hazard_unit_if #(
   parameter int unsigned CNT_W = 16
);
   // register ids
   logic [3:0]       Rs1D;
   logic [3:0]       Rs2D;
   logic [3:0]       Rs1E;
   logic [3:0]       Rs2E;
   logic [3:0]       RdE;
   logic [3:0]       RdM;
   logic [3:0]       RdW;
   // hazard sources
   logic [1:0]       resultSrcE;
   logic             regWriteM;
   logic             regWriteW;
   logic             PCSrcE;
   logic             memAccessM;
   logic             memReadyM;
   // controls back to the pipeline
   logic [1:0]       forwardAE;
   logic [1:0]       forwardBE;
   logic             stallF;
   logic             stallD;
   logic             stallE;
   logic             stallM;
   logic             flushD;
   logic             flushE;
   logic             flushW;
   logic             memErr;
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;
   logic [CNT_W-1:0] lwCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output resultSrcE, regWriteM, regWriteW, PCSrcE, memAccessM, memReadyM,
      input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
      input  flushD, flushE, flushW, memErr, stallCount, flushCount, lwCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  resultSrcE, regWriteM, regWriteW, PCSrcE, memAccessM, memReadyM,
      output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
      output flushD, flushE, flushW, memErr, stallCount, flushCount, lwCount
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the 16-bit five-stage core.
// This block produces the execute-stage operand forwarding selects. It also produces the
// F/D/E/M/W stall and flush controls for three cases: load-use hazards, taken branches,
// and data-memory wait states. A wait-state timeout FSM is included, together with
// saturating performance counters.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : hazard_unit_if.slave (register ids and hazard sources in; controls and counters out)
// All stall/flush/forward outputs are combinational from the current state and inputs.
// The memErr output and the counters are registered.
module hazard_unit #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   hazard_unit_if.slave  bus
);

   typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

   localparam logic [7:0]       TimeoutVal = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d;

   logic             lw_haz;
   logic             hold;       // full pipeline freeze (memory wait or error)
   logic             run_rules;  // evaluate branch / load-use rules this cycle
   logic             ev_branch;
   logic             ev_lw;
   logic             stall_f;

   function automatic logic [1:0] fwd_sel(input logic [3:0] rs, input logic wr_m,
                                          input logic [3:0] rd_m, input logic wr_w,
                                          input logic [3:0] rd_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (rd_m != 4'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != 4'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      logic [CNT_W-1:0] r;
      r = c;
      if (en && (c != {CNT_W{1'b1}})) begin
         r = c + CntOne;
      end
      return r;
   endfunction

   always_comb begin
      lw_haz = (bus.resultSrcE == 2'b01) && (bus.RdE != 4'd0) &&
               ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      hold       = 1'b0;
      run_rules  = 1'b0;

      case (state_q)
         StRun: begin
            // Branch and load-use are held off here; E and D are frozen, so they persist.
            if (bus.memAccessM && !bus.memReadyM) begin
               hold       = 1'b1;
               state_d    = StMemWait;
               wait_cnt_d = 8'd1;
            end else begin
               run_rules = 1'b1;
            end
         end
         StMemWait: begin
            if (bus.memReadyM) begin
               run_rules  = 1'b1;
               state_d    = StRun;
               wait_cnt_d = 8'd0;
            end else begin
               hold = 1'b1;
               if (wait_cnt_q == TimeoutVal) begin
                  state_d   = StError;
                  mem_err_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
         end
         StError: begin
            hold      = 1'b1;
            mem_err_d = 1'b1;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = 8'd0;
         end
      endcase

      // A taken branch squashes the instruction in D, so it overrides a load-use stall.
      ev_branch = run_rules && bus.PCSrcE;
      ev_lw     = run_rules && !bus.PCSrcE && lw_haz;
      stall_f   = rst && (hold || ev_lw);

      bus.forwardAE  = rst ? fwd_sel(bus.Rs1E, bus.regWriteM, bus.RdM, bus.regWriteW, bus.RdW)
                           : 2'b00;
      bus.forwardBE  = rst ? fwd_sel(bus.Rs2E, bus.regWriteM, bus.RdM, bus.regWriteW, bus.RdW)
                           : 2'b00;
      bus.stallF     = stall_f;
      bus.stallD     = stall_f;
      bus.stallE     = rst && hold;
      bus.stallM     = rst && hold;
      bus.flushD     = rst && ev_branch;
      bus.flushE     = rst && (ev_branch || ev_lw);
      bus.flushW     = rst && hold;
      bus.memErr     = mem_err_q;
      bus.stallCount = stall_cnt_q;
      bus.flushCount = flush_cnt_q;
      bus.lwCount    = lw_cnt_q;

      stall_cnt_d = sat_inc(stall_cnt_q, stall_f);
      flush_cnt_d = sat_inc(flush_cnt_q, ev_branch);
      lw_cnt_d    = sat_inc(lw_cnt_q, ev_lw);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         lw_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         lw_cnt_q    <= lw_cnt_d;
      end
   end

endmodule
